// File: rtl/aes_req_arbiter.sv
// rtl/aes_req_arbiter.sv - round-robin arbiter sharing one AES-128 core among NUM_REQ requesters
// Optional feature macro: AES_ARB_TIMEOUT_EN (abort a WAIT after TIMEOUT_CYCLES, flag timeout_err)
module aes_req_arbiter #(
  parameter int NUM_REQ        = 4,
  parameter int TIMEOUT_CYCLES = 64,
  localparam int ID_W          = $clog2(NUM_REQ)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [NUM_REQ-1:0]     req_valid,
  output logic [NUM_REQ-1:0]     req_ready,
  input  logic [NUM_REQ*128-1:0] req_plain_text_128,
  input  logic [NUM_REQ*128-1:0] req_key_128,
  output logic [NUM_REQ-1:0]     rsp_valid,
  input  logic [NUM_REQ-1:0]     rsp_ready,
  output logic [127:0]           rsp_cipher_text_128,
  output logic [ID_W-1:0]        rsp_id,
  output logic [127:0]           core_plain_text_128,
  output logic [127:0]           core_key_128,
  output logic                   core_valid_in,
  input  logic [127:0]           core_cipher_text_128,
  input  logic                   core_valid_out,
  output logic                   stray_out,
  output logic                   timeout_err
);

  if (NUM_REQ < 2 || NUM_REQ > 16 || TIMEOUT_CYCLES < 1) begin : g_bad_cfg
    $error("aes_req_arbiter: NUM_REQ must be 2..16 and TIMEOUT_CYCLES >= 1");
  end

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t               state;
  logic [ID_W-1:0]      rr_ptr;
  logic [ID_W-1:0]      owner;
  logic [127:0]         pt_q;
  logic [127:0]         key_q;
  logic [127:0]         result_q;
  logic [NUM_REQ-1:0]   rsp_valid_q;
  logic                 valid_in_q;
  logic                 stray_q;

  logic [NUM_REQ-1:0]   grant_oh;
  logic [ID_W-1:0]      grant_id;
  logic                 grant_found;
  int                   scan_idx;
  logic [127:0]         grant_pt;
  logic [127:0]         grant_key;
  logic [NUM_REQ-1:0]   owner_oh;

`ifdef AES_ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0]     wait_cnt;
  logic                 timeout_q;
`endif

  // Scan starts at rr_ptr and wraps, so the last served client has lowest priority.
  always_comb begin
    grant_oh    = '0;
    grant_id    = '0;
    grant_found = 1'b0;
    scan_idx    = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      scan_idx = int'(rr_ptr) + k;
      if (scan_idx >= NUM_REQ) scan_idx = scan_idx - NUM_REQ;
      if (!grant_found && req_valid[scan_idx]) begin
        grant_found        = 1'b1;
        grant_oh[scan_idx] = 1'b1;
        grant_id           = ID_W'(scan_idx);
      end
    end
  end

  always_comb begin
    grant_pt  = '0;
    grant_key = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant_oh[i]) begin
        grant_pt  = req_plain_text_128[i*128 +: 128];
        grant_key = req_key_128[i*128 +: 128];
      end
    end
  end

  assign owner_oh  = {{(NUM_REQ-1){1'b0}}, 1'b1} << owner;
  assign req_ready = (state == IDLE) ? grant_oh : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      rr_ptr      <= '0;
      owner       <= '0;
      pt_q        <= '0;
      key_q       <= '0;
      result_q    <= '0;
      rsp_valid_q <= '0;
      valid_in_q  <= 1'b0;
      stray_q     <= 1'b0;
`ifdef AES_ARB_TIMEOUT_EN
      wait_cnt    <= '0;
      timeout_q   <= 1'b0;
`endif
    end else begin
      valid_in_q <= 1'b0;
      // A core strobe is only meaningful while a block is outstanding.
      if (core_valid_out && state != WAIT) stray_q <= 1'b1;
      case (state)
        IDLE: begin
          if (grant_found) begin
            owner      <= grant_id;
            pt_q       <= grant_pt;
            key_q      <= grant_key;
            valid_in_q <= 1'b1;
            state      <= ISSUE;
          end
        end
        ISSUE: begin
          state <= WAIT;
`ifdef AES_ARB_TIMEOUT_EN
          wait_cnt <= '0;
`endif
        end
        WAIT: begin
          if (core_valid_out) begin
            result_q    <= core_cipher_text_128;
            rsp_valid_q <= owner_oh;
            state       <= RESP;
          end
`ifdef AES_ARB_TIMEOUT_EN
          else if (wait_cnt == CNT_W'(TIMEOUT_CYCLES - 1)) begin
            timeout_q   <= 1'b1;
            result_q    <= '0;
            rsp_valid_q <= owner_oh;
            state       <= RESP;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
`endif
        end
        RESP: begin
          if (rsp_ready[owner]) begin
            rsp_valid_q <= '0;
            rr_ptr      <= (owner == ID_W'(NUM_REQ - 1)) ? '0 : owner + 1'b1;
            state       <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign rsp_valid           = rsp_valid_q;
  assign rsp_id              = owner;
  assign rsp_cipher_text_128 = result_q;
  assign core_plain_text_128 = pt_q;
  assign core_key_128        = key_q;
  assign core_valid_in       = valid_in_q;
  assign stray_out           = stray_q;
`ifdef AES_ARB_TIMEOUT_EN
  assign timeout_err         = timeout_q;
`else
  assign timeout_err         = 1'b0;
`endif

endmodule

// File: tb/tb_aes_req_arbiter.sv
// tb/tb_aes_req_arbiter.sv - randomized bench for aes_req_arbiter with a transaction-level model
// Honours AES_ARB_TIMEOUT_EN when defined (adds the silent-core timeout scenario).
`timescale 1ns/1ps
module tb_aes_req_arbiter;
  localparam int N   = 4;
  localparam int TO  = 8;
  localparam int IDW = $clog2(N);
  localparam logic [127:0] TV_PT  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] TV_KEY = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] TV_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

  logic             clk = 1'b0;
  logic             rst_n = 1'b1;
  logic [N-1:0]     req_valid = '0;
  logic [N-1:0]     req_ready;
  logic [N*128-1:0] req_pt = '0;
  logic [N*128-1:0] req_key = '0;
  logic [N-1:0]     rsp_valid;
  logic [N-1:0]     rsp_ready = '0;
  logic [127:0]     rsp_ct;
  logic [IDW-1:0]   rsp_id;
  logic [127:0]     core_pt, core_key;
  logic             core_vin;
  logic [127:0]     core_ct = '0;
  logic             core_vout = 1'b0;
  logic             stray_out, timeout_err;

  int checks = 0;
  int fails  = 0;

  aes_req_arbiter #(.NUM_REQ(N), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_plain_text_128(req_pt), .req_key_128(req_key),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_cipher_text_128(rsp_ct), .rsp_id(rsp_id),
    .core_plain_text_128(core_pt), .core_key_128(core_key),
    .core_valid_in(core_vin),
    .core_cipher_text_128(core_ct), .core_valid_out(core_vout),
    .stray_out(stray_out), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s @%0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  // Stand-in for the AES core: the known vector maps to its real ciphertext, anything else to a keyed mix.
  function automatic logic [127:0] core_fn(input logic [127:0] pt, input logic [127:0] key);
    if (pt == TV_PT && key == TV_KEY) return TV_CT;
    return pt ^ {key[63:0], key[127:64]} ^ 128'ha5a5_5a5a_0f0f_f0f0_3c3c_c3c3_9696_6969;
  endfunction

  // Transaction-level reference: who owns the core, and what the client is owed.
  bit           m_busy, m_issue, m_wait, m_result, m_stray, m_tout;
  int           m_last, m_owner, m_wcnt, g;
  logic [127:0] m_pt, m_key, m_ct;
  logic [N-1:0] exp_rr, exp_rv;
  int           grant_log[$];

  logic [N-1:0] smp_accept = '0;
  logic         smp_vin = 1'b0;
  logic [127:0] smp_pt = '0, smp_key = '0;

  always @(negedge clk) begin
    if (!rst_n) begin
      chk("rst_req_ready", req_ready, 0);
      chk("rst_rsp_valid", rsp_valid, 0);
      chk("rst_rsp_id", rsp_id, 0);
      chk("rst_rsp_ct", rsp_ct, 0);
      chk("rst_core_vin", core_vin, 0);
      chk("rst_core_pt", core_pt, 0);
      chk("rst_core_key", core_key, 0);
      chk("rst_stray", stray_out, 0);
      chk("rst_timeout", timeout_err, 0);
      m_busy = 0; m_issue = 0; m_wait = 0; m_result = 0; m_stray = 0; m_tout = 0;
      m_last = N - 1; m_owner = 0; m_wcnt = 0;
      smp_accept = '0; smp_vin = 1'b0;
    end else begin
      g = -1;
      if (!m_busy)
        for (int k = 1; k <= N; k++)
          if (g < 0 && req_valid[(m_last + k) % N]) g = (m_last + k) % N;
      exp_rr = '0;
      if (g >= 0) exp_rr[g] = 1'b1;
      exp_rv = '0;
      if (m_result) exp_rv[m_owner] = 1'b1;

      chk("req_ready", req_ready, exp_rr);
      chk("core_valid_in", core_vin, m_issue);
      chk("rsp_valid", rsp_valid, exp_rv);
      chk("stray_out", stray_out, m_stray);
      chk("timeout_err", timeout_err, m_tout);
      if (m_result) begin
        chk("rsp_id", rsp_id, m_owner);
        chk("rsp_cipher", rsp_ct, m_ct);
      end
      if (m_issue || m_wait) begin
        chk("core_pt", core_pt, m_pt);
        chk("core_key", core_key, m_key);
      end

      if (core_vout && !m_wait) m_stray = 1;
      if (m_result) begin
        if (rsp_ready[m_owner]) begin
          m_result = 0; m_busy = 0; m_last = m_owner;
        end
      end else if (m_wait) begin
        if (core_vout) begin
          m_wait = 0; m_result = 1; m_ct = core_fn(m_pt, m_key);
        end else begin
          m_wcnt++;
`ifdef AES_ARB_TIMEOUT_EN
          if (m_wcnt == TO) begin
            m_wait = 0; m_result = 1; m_ct = '0; m_tout = 1;
          end
`endif
        end
      end else if (m_issue) begin
        m_issue = 0; m_wait = 1; m_wcnt = 0;
      end
      if (g >= 0) begin
        m_busy = 1; m_issue = 1; m_owner = g;
        m_pt = req_pt[g*128 +: 128]; m_key = req_key[g*128 +: 128];
        grant_log.push_back(g);
      end

      smp_accept = req_valid & req_ready;
      smp_vin    = core_vin;
      if (core_vin) begin
        smp_pt  = core_pt;
        smp_key = core_key;
      end
    end
  end

  int core_cnt = -1;
  bit core_silent = 0;
  bit seen;
  int exp_order[5] = '{0, 1, 2, 3, 0};

  task automatic step_core();
    core_vout = 1'b0;
    core_ct   = {$urandom, $urandom, $urandom, $urandom};
    if (smp_vin) core_cnt = $urandom_range(0, 5);
    if (core_cnt == 0) begin
      if (!core_silent) begin
        core_vout = 1'b1;
        core_ct   = core_fn(smp_pt, smp_key);
      end
      core_cnt = -1;
    end else if (core_cnt > 0) begin
      core_cnt--;
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
    step_core();
  endtask

  task automatic new_data(input int i);
    req_pt[i*128 +: 128]  = {$urandom, $urandom, $urandom, $urandom};
    req_key[i*128 +: 128] = {$urandom, $urandom, $urandom, $urandom};
  endtask

  task automatic step_req(input bit continuous);
    for (int i = 0; i < N; i++) begin
      if (continuous) begin
        if (smp_accept[i]) new_data(i);
        req_valid[i] = 1'b1;
      end else if (smp_accept[i]) begin
        req_valid[i] = 1'b0;
      end else if (req_valid[i]) begin
        if ($urandom_range(0, 15) == 0) req_valid[i] = 1'b0;
      end else if ($urandom_range(0, 2) == 0) begin
        new_data(i);
        req_valid[i] = 1'b1;
      end
    end
  endtask

  initial begin
    #1 rst_n = 1'b0;
    repeat (3) cyc();
    rst_n = 1'b1;

    // All clients requesting continuously from reset.
    for (int i = 0; i < N; i++) new_data(i);
    rsp_ready = '1;
    repeat (80) begin
      cyc();
      step_req(1'b1);
    end
    chk("t2_grant_count", grant_log.size() >= 5, 1);
    for (int k = 0; k < 5; k++)
      if (k < grant_log.size()) chk($sformatf("t2_grant_%0d", k), grant_log[k], exp_order[k]);

    // Reset while the core is busy: the block is dropped without a response.
    seen = 0;
    for (int t = 0; t < 40 && !seen; t++) begin
      cyc();
      step_req(1'b1);
      if (smp_vin) seen = 1;
    end
    chk("t5_reached_wait", seen, 1);
    rst_n = 1'b0; req_valid = '0; rsp_ready = '0; core_vout = 1'b0; core_cnt = -1;
    cyc();
    chk("t5_rsp_valid_in_rst", rsp_valid, 0);
    chk("t5_core_vin_in_rst", core_vin, 0);
    cyc();
    rst_n = 1'b1;
    repeat (6) cyc();
    chk("t5_no_rsp_after_rst", rsp_valid, 0);

    // Known vector from requester 2, then a 10-cycle response stall.
    req_pt[2*128 +: 128] = TV_PT;
    req_key[2*128 +: 128] = TV_KEY;
    req_valid = 4'b0100;
    seen = 0;
    for (int t = 0; t < 40 && !seen; t++) begin
      cyc();
      if (smp_accept[2]) req_valid[2] = 1'b0;
      if (rsp_valid != 0) seen = 1;
    end
    chk("t1_rsp_seen", seen, 1);
    chk("t1_rsp_valid", rsp_valid, 4'b0100);
    chk("t1_rsp_id", rsp_id, 2);
    chk("t1_cipher", rsp_ct, TV_CT);
    new_data(0); new_data(1); new_data(3);
    req_valid = 4'b1011;
    rsp_ready = 4'b1011;
    repeat (10) cyc();
    chk("t3_rsp_valid_held", rsp_valid, 4'b0100);
    chk("t3_cipher_held", rsp_ct, TV_CT);
    chk("t3_no_req_ready", req_ready, 0);
    rsp_ready = 4'b0100;
    cyc();
    req_valid = '0;
    rsp_ready = '0;

`ifdef AES_ARB_TIMEOUT_EN
    // Silent core: the arbiter must give up after TO wait cycles and answer with zero.
    core_silent = 1;
    new_data(0);
    req_valid = 4'b0001;
    seen = 0;
    for (int t = 0; t < 40 && !seen; t++) begin
      cyc();
      if (smp_accept[0]) req_valid[0] = 1'b0;
      if (rsp_valid != 0) seen = 1;
    end
    chk("t6_rsp_seen", seen, 1);
    chk("t6_timeout_err", timeout_err, 1);
    chk("t6_rsp_valid", rsp_valid, 4'b0001);
    chk("t6_cipher_zero", rsp_ct, 0);
    rsp_ready = 4'b0001;
    cyc();
    rsp_ready = '0;
    core_silent = 0;
`endif

    // Core strobe while idle.
    cyc();
    core_vout = 1'b1;
    cyc();
    chk("t4_stray", stray_out, 1);
    chk("t4_no_rsp", rsp_valid, 0);

    // Random traffic, withdrawals and back-pressure.
    repeat (3000) begin
      cyc();
      step_req(1'b0);
      rsp_ready = N'($urandom);
    end
    chk("t4_stray_sticky", stray_out, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, checks %0d failures %0d", checks, fails);
    $fatal(1, "watchdog");
  end

endmodule
